// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared types and opcode constants for the immediate-decode
//                pipe stage (immediate-type tag, RV opcodes, shift funct3).
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

   // Immediate-format tag carried alongside each decoded entry
   typedef enum logic [2:0] {
      IMM_NONE  = 3'd0,
      IMM_I     = 3'd1,
      IMM_S     = 3'd2,
      IMM_B     = 3'd3,
      IMM_U     = 3'd4,
      IMM_J     = 3'd5,
      IMM_SHAMT = 3'd6,
      IMM_ZIMM  = 3'd7
   } imm_type_e;

   // Major opcodes (inst[6:0])
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   // Shift-immediate funct3 encodings
   localparam logic [2:0] FUNCT3_SLL = 3'b001;
   localparam logic [2:0] FUNCT3_SRX = 3'b101;

   // True when an OP-IMM / OP-IMM-32 funct3 selects a shift
   function automatic logic is_shift(input logic [2:0] funct3);
      return (funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extract
//  Description : Combinational immediate extractor. Maps a raw 32-bit
//                instruction to an XLEN-wide immediate, its format tag and
//                an illegal flag for undecodable opcodes/fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit EN_ZICSR = 1'b1
) (
   input  logic [31:0]     i_inst,
   output logic [XLEN-1:0] o_imm,
   output imm_type_e       o_type,
   output logic            o_illegal
);

   logic [6:0]      w_opc;
   logic [2:0]      w_funct3;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_b;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_imm_j;

   assign w_opc    = i_inst[6:0];
   assign w_funct3 = i_inst[14:12];

   // Signed size casts replicate inst[31] up to XLEN
   assign w_imm_i = XLEN'($signed(i_inst[31:20]));
   assign w_imm_s = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
   assign w_imm_b = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
   assign w_imm_u = XLEN'($signed({i_inst[31:12], 12'b0}));
   assign w_imm_j = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));

   // Opcode-driven format select; unknown opcodes fall to IMM_NONE/illegal
   always_comb begin
      o_imm     = '0;
      o_type    = IMM_NONE;
      o_illegal = 1'b0;
      case (w_opc)
         OPC_OP_IMM: begin
            if (is_shift(w_funct3)) begin
               o_type = IMM_SHAMT;
               if (XLEN == 64) begin
                  o_imm = XLEN'(i_inst[25:20]);
               end else begin
                  // RV32 shifts only have a 5-bit shamt; bit 25 set is reserved
                  o_imm     = XLEN'(i_inst[24:20]);
                  o_illegal = i_inst[25];
               end
            end else begin
               o_type = IMM_I;
               o_imm  = w_imm_i;
            end
         end
         OPC_OP_IMM_32: begin
            if (XLEN == 32) begin
               o_illegal = 1'b1;
            end else if (is_shift(w_funct3)) begin
               // Word shifts are always 5-bit shamt
               o_type    = IMM_SHAMT;
               o_imm     = XLEN'(i_inst[24:20]);
               o_illegal = i_inst[25];
            end else begin
               o_type = IMM_I;
               o_imm  = w_imm_i;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            o_type = IMM_I;
            o_imm  = w_imm_i;
         end
         OPC_STORE: begin
            o_type = IMM_S;
            o_imm  = w_imm_s;
         end
         OPC_BRANCH: begin
            o_type = IMM_B;
            o_imm  = w_imm_b;
         end
         OPC_LUI, OPC_AUIPC: begin
            o_type = IMM_U;
            o_imm  = w_imm_u;
         end
         OPC_JAL: begin
            o_type = IMM_J;
            o_imm  = w_imm_j;
         end
         OPC_SYSTEM: begin
            if (!EN_ZICSR) begin
               o_illegal = 1'b1;
            end else if (w_funct3[2]) begin
               // CSRRxI: rs1 field carries a zero-extended 5-bit immediate
               o_type = IMM_ZIMM;
               o_imm  = XLEN'(i_inst[19:15]);
            end
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/imm_decode_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode_pipe
//  Description : Registered immediate-generation stage with valid/ready
//                handshake and a 2-entry (output + skid) buffer. Decodes at
//                the input; buffered entries carry decoded results.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_pipe
   import imm_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit EN_ZICSR = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] imm_o,
   output imm_type_e       imm_type_o,
   output logic            illegal_o,
   output logic [XLEN-1:0] pc_o
);

   generate
      if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
         $error("imm_decode_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   logic [XLEN-1:0] w_dec_imm;
   imm_type_e       w_dec_type;
   logic            w_dec_ill;
   logic            w_accept;
   logic            w_pop;

   logic            r_out_valid;
   logic [XLEN-1:0] r_out_imm;
   imm_type_e       r_out_type;
   logic            r_out_ill;
   logic [XLEN-1:0] r_out_pc;

   logic            r_skid_valid;
   logic [XLEN-1:0] r_skid_imm;
   imm_type_e       r_skid_type;
   logic            r_skid_ill;
   logic [XLEN-1:0] r_skid_pc;

   imm_extract #(
      .XLEN     (XLEN),
      .EN_ZICSR (EN_ZICSR)
   ) u_extract (
      .i_inst    (inst_i),
      .o_imm     (w_dec_imm),
      .o_type    (w_dec_type),
      .o_illegal (w_dec_ill)
   );

   // Ready depends only on skid occupancy, so no comb path from out_ready_i
   assign in_ready_o = !r_skid_valid;
   assign w_accept   = in_valid_i && !r_skid_valid;
   assign w_pop      = r_out_valid && out_ready_i;

   assign out_valid_o = r_out_valid;
   assign imm_o       = r_out_imm;
   assign imm_type_o  = r_out_type;
   assign illegal_o   = r_out_ill;
   assign pc_o        = r_out_pc;

   // Output/skid buffer update: skid drains first to keep FIFO order
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_imm    <= '0;
         r_out_type   <= IMM_NONE;
         r_out_ill    <= 1'b0;
         r_out_pc     <= '0;
         r_skid_valid <= 1'b0;
         r_skid_imm   <= '0;
         r_skid_type  <= IMM_NONE;
         r_skid_ill   <= 1'b0;
         r_skid_pc    <= '0;
      end else if (flush_i) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (r_out_valid && !w_pop) begin
         // Output stalled: hold it, park a new entry in the (empty) skid
         if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_dec_imm;
            r_skid_type  <= w_dec_type;
            r_skid_ill   <= w_dec_ill;
            r_skid_pc    <= pc_i;
         end
      end else if (r_skid_valid) begin
         // Output free or popping: the older skid entry moves up
         r_out_valid  <= 1'b1;
         r_out_imm    <= r_skid_imm;
         r_out_type   <= r_skid_type;
         r_out_ill    <= r_skid_ill;
         r_out_pc     <= r_skid_pc;
         r_skid_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_imm   <= w_dec_imm;
         r_out_type  <= w_dec_type;
         r_out_ill   <= w_dec_ill;
         r_out_pc    <= pc_i;
      end else begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire
